// File: rtl/bp_cce_spec_resolver.sv
// bp_cce_spec_resolver: resolves memory responses against CCE speculation bits, then clears the metadata
module bp_cce_spec_resolver #(
  parameter int addr_width_p      = 40,
  parameter int coh_state_width_p = 3,
  parameter int cnt_width_p       = 16,
  localparam int spec_width_lp    = 3 + coh_state_width_p
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         mem_resp_v_i,
  output logic                         mem_resp_ready_o,
  input  logic [addr_width_p-1:0]      mem_resp_addr_i,
  input  logic [coh_state_width_p-1:0] mem_resp_state_i,
  output logic                         spec_r_v_o,
  output logic [addr_width_p-1:0]      spec_r_addr_o,
  output logic                         spec_r_addr_bypass_o,
  input  logic [spec_width_lp-1:0]     spec_i,
  output logic                         spec_w_v_o,
  output logic [addr_width_p-1:0]      spec_w_addr_o,
  output logic                         spec_w_addr_bypass_o,
  output logic                         spec_v_o,
  output logic                         squash_v_o,
  output logic                         fwd_mod_v_o,
  output logic                         state_v_o,
  output logic [spec_width_lp-1:0]     spec_o,
  output logic                         resp_v_o,
  input  logic                         resp_yumi_i,
  output logic [addr_width_p-1:0]      resp_addr_o,
  output logic [coh_state_width_p-1:0] resp_state_o,
  output logic                         resp_spec_o,
  output logic [cnt_width_p-1:0]       squash_cnt_o
);
  localparam logic [1:0] e_ready  = 2'd0;
  localparam logic [1:0] e_lookup = 2'd1;
  localparam logic [1:0] e_send   = 2'd2;
  localparam logic [1:0] e_clear  = 2'd3;
  logic [1:0] state_q, state_d;
  logic [addr_width_p-1:0] addr_q;
  logic [coh_state_width_p-1:0] req_state_q, resp_state_q;
  logic resp_spec_q;
  logic [cnt_width_p-1:0] cnt_q, cnt_d;
  logic rd_spec, rd_squash, rd_fwd_mod, squash;
  logic [coh_state_width_p-1:0] rd_state;
  assign rd_spec    = spec_i[spec_width_lp-1];
  assign rd_squash  = spec_i[spec_width_lp-2];
  assign rd_fwd_mod = spec_i[spec_width_lp-3];
  assign rd_state   = spec_i[coh_state_width_p-1:0];
  assign squash     = rd_spec & rd_squash;
  always_comb begin
    state_d = (state_q == e_ready)  ? (mem_resp_v_i ? e_lookup : e_ready)
            : (state_q == e_lookup) ? (squash ? e_clear : e_send)
            : (state_q == e_send)   ? (resp_yumi_i ? (resp_spec_q ? e_clear : e_ready) : e_send)
            : e_ready;
    cnt_d = (state_q == e_lookup && squash && ~&cnt_q) ? cnt_q + cnt_width_p'(1) : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= e_ready;
      addr_q       <= '0;
      req_state_q  <= '0;
      resp_state_q <= '0;
      resp_spec_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == e_ready && mem_resp_v_i) begin
        addr_q      <= mem_resp_addr_i;
        req_state_q <= mem_resp_state_i;
      end
      if (state_q == e_lookup) begin
        resp_state_q <= (rd_spec & rd_fwd_mod) ? rd_state : req_state_q;
        resp_spec_q  <= rd_spec;
      end
    end
  end
  assign mem_resp_ready_o     = state_q == e_ready;
  assign spec_r_v_o           = state_q == e_lookup;
  assign spec_r_addr_o        = addr_q;
  assign spec_r_addr_bypass_o = 1'b0;
  assign spec_w_v_o           = state_q == e_clear;
  assign spec_w_addr_o        = addr_q;
  assign spec_w_addr_bypass_o = 1'b0;
  assign spec_v_o             = spec_w_v_o;
  assign squash_v_o           = spec_w_v_o;
  assign fwd_mod_v_o          = spec_w_v_o;
  assign state_v_o            = 1'b0;
  assign spec_o               = '0;
  assign resp_v_o             = state_q == e_send;
  assign resp_addr_o          = addr_q;
  assign resp_state_o         = resp_state_q;
  assign resp_spec_o          = resp_spec_q;
  assign squash_cnt_o         = cnt_q;
endmodule

// File: tb/tb_bp_cce_spec_resolver.sv
// tb_bp_cce_spec_resolver: scoreboard bench for the speculation resolver
module tb_bp_cce_spec_resolver;
  localparam int aw = 16;
  localparam int sw = 3;
  localparam int cw = 2;
  logic clk = 0;
  logic reset_i;
  logic mem_resp_v_i, mem_resp_ready_o;
  logic [aw-1:0] mem_resp_addr_i;
  logic [sw-1:0] mem_resp_state_i;
  logic spec_r_v_o, spec_r_addr_bypass_o, spec_w_v_o, spec_w_addr_bypass_o;
  logic [aw-1:0] spec_r_addr_o, spec_w_addr_o, resp_addr_o;
  logic [sw+2:0] spec_i, spec_o;
  logic spec_v_o, squash_v_o, fwd_mod_v_o, state_v_o;
  logic resp_v_o, resp_yumi_i, resp_spec_o;
  logic [sw-1:0] resp_state_o;
  logic [cw-1:0] squash_cnt_o;
  int tests = 0, fails = 0;
  int cnt_m = 0;
  logic [aw+sw:0] rq[$];
  logic [aw-1:0] wq[$];
  always #5 clk = ~clk;
  bp_cce_spec_resolver #(.addr_width_p(aw), .coh_state_width_p(sw), .cnt_width_p(cw)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
    .mem_resp_addr_i(mem_resp_addr_i), .mem_resp_state_i(mem_resp_state_i),
    .spec_r_v_o(spec_r_v_o), .spec_r_addr_o(spec_r_addr_o), .spec_r_addr_bypass_o(spec_r_addr_bypass_o),
    .spec_i(spec_i),
    .spec_w_v_o(spec_w_v_o), .spec_w_addr_o(spec_w_addr_o), .spec_w_addr_bypass_o(spec_w_addr_bypass_o),
    .spec_v_o(spec_v_o), .squash_v_o(squash_v_o), .fwd_mod_v_o(fwd_mod_v_o), .state_v_o(state_v_o),
    .spec_o(spec_o),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_addr_o(resp_addr_o),
    .resp_state_o(resp_state_o), .resp_spec_o(resp_spec_o), .squash_cnt_o(squash_cnt_o)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always begin
    @(negedge clk);
    #2;
    if (!reset_i) begin
      if (spec_r_v_o && spec_w_v_o) chk("rw_excl", 1, 0);
      if (resp_v_o && resp_yumi_i) begin
        if (rq.size() == 0) chk("resp_unexp", 1, 0);
        else chk("resp", {resp_addr_o, resp_state_o, resp_spec_o}, rq.pop_front());
      end
      if (spec_w_v_o) begin
        if (wq.size() == 0) chk("wr_unexp", 1, 0);
        else chk("wr", {spec_w_addr_o, spec_v_o, squash_v_o, fwd_mod_v_o, state_v_o, spec_o},
                 {wq.pop_front(), 4'b1110, 6'b0});
      end
    end
  end
  task automatic txn(input logic [aw-1:0] a, input logic [sw-1:0] st,
                     input logic s, input logic q, input logic f, input logic [sw-1:0] sst,
                     input int hold);
    int n = 0;
    logic [aw+sw:0] e;
    @(negedge clk);
    while (!mem_resp_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_resp_ready_o) chk("ready_timeout", 0, 1);
    spec_i = {s, q, f, sst};
    mem_resp_v_i = 1;
    mem_resp_addr_i = a;
    mem_resp_state_i = st;
    e = {a, (s && f) ? sst : st, s};
    if (!(s && q)) rq.push_back(e);
    if (s) wq.push_back(a);
    @(posedge clk);
    #1 mem_resp_v_i = 0;
    @(negedge clk);
    chk("lookup_rv", spec_r_v_o, 1);
    chk("lookup_addr", spec_r_addr_o, a);
    chk("lookup_ready", mem_resp_ready_o, 0);
    @(negedge clk);
    if (s && q) begin
      if (cnt_m < 3) cnt_m++;
      chk("sq_resp_v", resp_v_o, 0);
      chk("sq_wv", spec_w_v_o, 1);
      @(negedge clk);
      chk("sq_ready", mem_resp_ready_o, 1);
      chk("sq_resp_v2", resp_v_o, 0);
      chk("sq_cnt", squash_cnt_o, cnt_m);
    end else begin
      chk("resp_v", resp_v_o, 1);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_v", resp_v_o, 1);
        chk("hold_ready", mem_resp_ready_o, 0);
        chk("hold_fields", {resp_addr_o, resp_state_o, resp_spec_o}, e);
      end
      resp_yumi_i = 1;
      @(posedge clk);
      #1 resp_yumi_i = 0;
      @(negedge clk);
      chk("post_resp_v", resp_v_o, 0);
      if (s) begin
        chk("clr_wv", spec_w_v_o, 1);
        chk("clr_ready", mem_resp_ready_o, 0);
        @(negedge clk);
      end else chk("ns_wv", spec_w_v_o, 0);
      chk("post_ready", mem_resp_ready_o, 1);
    end
  endtask
  initial begin
    reset_i = 1;
    mem_resp_v_i = 0;
    mem_resp_addr_i = 0;
    mem_resp_state_i = 0;
    spec_i = 0;
    resp_yumi_i = 0;
    repeat (2) @(posedge clk);
    #1 reset_i = 0;
    @(negedge clk);
    chk("rst_ready", mem_resp_ready_o, 1);
    chk("rst_valids", {spec_r_v_o, spec_w_v_o, resp_v_o}, 0);
    chk("rst_cnt", squash_cnt_o, 0);
    chk("bypass", {spec_r_addr_bypass_o, spec_w_addr_bypass_o}, 0);
    txn(16'h1000, 3, 0, 0, 0, 0, 0);
    txn(16'h1000, 3, 1, 0, 0, 5, 0);
    txn(16'h1000, 3, 1, 0, 1, 2, 0);
    txn(16'h2000, 1, 1, 1, 0, 0, 0);
    txn(16'h3000, 4, 1, 0, 1, 6, 5);
    txn(16'h4000, 2, 0, 1, 1, 7, 3);
    for (int i = 0; i < 4; i++) txn(16'h5000 + 16'(i), 2, 1, 1, i[0], 16'(i) == 0 ? 3'd0 : 3'd7, 0);
    txn(16'h6000, 5, 1, 0, 0, 1, 2);
    spec_i = {1'b1, 1'b0, 1'b1, 3'd1};
    @(negedge clk);
    mem_resp_v_i = 1;
    mem_resp_addr_i = 16'h7000;
    mem_resp_state_i = 6;
    @(posedge clk);
    #1 mem_resp_v_i = 0;
    repeat (2) @(negedge clk);
    chk("pre_rst_v", resp_v_o, 1);
    reset_i = 1;
    @(posedge clk);
    #1 reset_i = 0;
    cnt_m = 0;
    @(negedge clk);
    chk("mid_rst_v", resp_v_o, 0);
    chk("mid_rst_ready", mem_resp_ready_o, 1);
    chk("mid_rst_wv", spec_w_v_o, 0);
    chk("mid_rst_cnt", squash_cnt_o, 0);
    @(negedge clk);
    chk("mid_rst_wv2", spec_w_v_o, 0);
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
